bcd_seg7_decoder: RTL and testbench

- Converts a 32-bit unsigned binary value into four BCD digits.
- Drives four active-low 7-segment digit codes, one per digit.
- Sits between the processor output port and the board's HEX displays; the output module wraps it.
- Outputs are registered: one clock of latency from input to display codes.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/bcd_seg7_decoder_if.sv | 40 ++++
 rtl/seg7_digit.sv | 33 +++
 rtl/bcd_seg7_decoder.sv | 72 +++++++
 tb/tb_bcd_seg7_decoder.sv | 135 +++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the binary-to-BCD / 7-segment display path.
//   - seg_t        : active-low segment code, bit order {g,f,e,d,c,b,a}
//   - SEG_0..SEG_9 : codes for the decimal digits (0 = segment lit)
//   - SEG_BLANK    : all segments dark, used for non-decimal nibbles
//   - SEG_RESET    : code shown while the display is held in reset
//   - NUM_DIGITS   : number of decimal digits produced and displayed
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] bcd_digit_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_RESET = SEG_0;

endpackage : seg7_pkg

// File: rtl/bcd_seg7_decoder_if.sv
// -----------------------------------------------------------------------------
// bcd_seg7_decoder_if
// Bundles the data path between the processor output port and the HEX display
// driver.
//   bin_in  : 32-bit unsigned value to display (driven by the master)
//   bcd_out : registered BCD digits {thousands, hundreds, tens, ones}
//   seg0..3 : registered active-low segment codes, seg0 = ones digit
// Modports:
//   master : the producer of bin_in (processor port / testbench)
//   slave  : the decoder itself
// -----------------------------------------------------------------------------
interface bcd_seg7_decoder_if;
  import seg7_pkg::*;

  logic [31:0] bin_in;
  logic [15:0] bcd_out;
  seg_t        seg0;
  seg_t        seg1;
  seg_t        seg2;
  seg_t        seg3;

  modport master (
    output bin_in,
    input  bcd_out,
    input  seg0,
    input  seg1,
    input  seg2,
    input  seg3
  );

  modport slave (
    input  bin_in,
    output bcd_out,
    output seg0,
    output seg1,
    output seg2,
    output seg3
  );

endinterface : bcd_seg7_decoder_if

// File: rtl/seg7_digit.sv
// -----------------------------------------------------------------------------
// seg7_digit
// Purely combinational BCD digit to active-low 7-segment decoder.
// Ports:
//   digit_i : 4-bit BCD digit (10..15 are not decimal and decode to blank)
//   seg_o   : active-low segment code {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_digit
  import seg7_pkg::*;
(
  input  bcd_digit_t digit_i,
  output seg_t       seg_o
);

  always_comb begin
    // NOTE: a default assignment on every path keeps this block free of latches.
    seg_o = SEG_BLANK;
    unique case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule : seg7_digit

// File: rtl/bcd_seg7_decoder.sv
// -----------------------------------------------------------------------------
// bcd_seg7_decoder
// Converts a 32-bit unsigned binary value to its four least-significant decimal
// digits (bin_in mod 10000) and drives one active-low 7-segment code per digit.
// Leading zeros are shown. All outputs are registered: one clock of latency.
// Ports:
//   clk   : system clock, rising-edge active
//   reset : synchronous, active-high; loads bcd_out = 0 and all segs = "0"
//   bus   : slave side of bcd_seg7_decoder_if (bin_in in, bcd_out/seg0..3 out)
// -----------------------------------------------------------------------------
module bcd_seg7_decoder
  import seg7_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  bcd_seg7_decoder_if.slave        bus
);

  // A 32-bit value needs ten decimal digits. The full double dabble is run and
  // only the low four digits kept; the add-3 corrections of the low digits do
  // not depend on the discarded high ones, so truncating at the end is exact.
  localparam int FULL_DIGITS = 10;

  function automatic logic [15:0] bin_to_bcd4(input logic [31:0] bin);
    logic [FULL_DIGITS*4-1:0] bcd;
    bcd = '0;
    for (int i = 31; i >= 0; i--) begin
      for (int d = 0; d < FULL_DIGITS; d++) begin
        if (bcd[d*4 +: 4] >= 4'd5) begin
          bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
        end
      end
      bcd = {bcd[FULL_DIGITS*4-2:0], bin[i]};
    end
    return bcd[NUM_DIGITS*4-1:0];
  endfunction

  logic [15:0] bcd_d, bcd_q;
  seg_t        seg_d [NUM_DIGITS];
  seg_t        seg_q [NUM_DIGITS];

  always_comb begin
    bcd_d = bin_to_bcd4(bus.bin_in);
  end

  // Segment codes are decoded from the next-state digits so that bcd_out and
  // seg0..seg3 always update on the same edge.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seg7_digit u_digit (
      .digit_i (bcd_d[g*4 +: 4]),
      .seg_o   (seg_d[g])
    );
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      bcd_q <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) seg_q[i] <= SEG_RESET;
    end else begin
      bcd_q <= bcd_d;
      for (int i = 0; i < NUM_DIGITS; i++) seg_q[i] <= seg_d[i];
    end
  end

  assign bus.bcd_out = bcd_q;
  assign bus.seg0    = seg_q[0];
  assign bus.seg1    = seg_q[1];
  assign bus.seg2    = seg_q[2];
  assign bus.seg3    = seg_q[3];

endmodule : bcd_seg7_decoder

// File: tb/tb_bcd_seg7_decoder.sv
// -----------------------------------------------------------------------------
// tb_bcd_seg7_decoder
// Directed self-checking bench for bcd_seg7_decoder. Inputs change on the
// falling edge; outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_bcd_seg7_decoder;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  bcd_seg7_decoder_if bus_if ();

  bcd_seg7_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written active-low codes for digits 0..9, {g,f,e,d,c,b,a}.
  logic [6:0] seg_tab [10];
  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
    seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Checks bcd_out and all four segment codes against an expected BCD value.
  task automatic check_all(input string tag, input logic [15:0] exp_bcd);
    logic [6:0] segs [4];
    logic [3:0] nib;
    segs[0] = bus_if.seg0; segs[1] = bus_if.seg1;
    segs[2] = bus_if.seg2; segs[3] = bus_if.seg3;
    check({tag, "_bcd"}, 32'(bus_if.bcd_out), 32'(exp_bcd));
    for (int i = 0; i < 4; i++) begin
      nib = exp_bcd[i*4 +: 4];
      check($sformatf("%s_seg%0d", tag, i), 32'(segs[i]), 32'(seg_tab[nib]));
    end
  endtask

  // Drive a value, wait for the registering edge, then sample.
  task automatic apply(input logic [31:0] v);
    @(negedge clk);
    bus_if.bin_in = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    bus_if.bin_in = 32'd1234;

    // Reset held two cycles with 1234 on the input: must read zero.
    @(posedge clk); #1;
    check_all("rst_c1", 16'h0000);
    @(posedge clk); #1;
    check_all("rst_c2", 16'h0000);

    // Release reset; next edge shows 1234.
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_all("v1234", 16'h1234);
    check("v1234_seg3_lit", 32'(bus_if.seg3), 32'h79);  // 1111001
    check("v1234_seg0_lit", 32'(bus_if.seg0), 32'h19);  // 0011001

    // Latency: after changing input, outputs hold until the next edge.
    @(negedge clk);
    bus_if.bin_in = 32'd7;
    #1;
    check("hold_before_edge", 32'(bus_if.bcd_out), 32'h1234);
    @(posedge clk); #1;
    check_all("lead_zero_7", 16'h0007);
    check("lead_zero_seg0", 32'(bus_if.seg0), 32'h78);  // 1111000
    check("lead_zero_seg3", 32'(bus_if.seg3), 32'h40);  // 1000000

    // Every single digit on the ones position.
    for (int d = 0; d < 10; d++) begin
      apply(32'(d));
      check_all($sformatf("digit%0d", d), 16'(d));
    end

    apply(32'd9999);
    check_all("v9999", 16'h9999);
    check("v9999_seg2", 32'(bus_if.seg2), 32'h10);      // 0010000

    // Truncation to the low four decimal digits.
    apply(32'd10000);
    check_all("v10000", 16'h0000);
    apply(32'd12345);
    check_all("v12345", 16'h2345);
    apply(32'hFFFF_FFFF);
    check_all("vmax", 16'h7295);
    check("vmax_seg3", 32'(bus_if.seg3), 32'h78);       // 1111000
    check("vmax_seg2", 32'(bus_if.seg2), 32'h24);       // 0100100
    check("vmax_seg1", 32'(bus_if.seg1), 32'h10);       // 0010000
    check("vmax_seg0", 32'(bus_if.seg0), 32'h12);       // 0010010

    // A few mixed values with hand-computed residues.
    apply(32'd90817);      check_all("v90817", 16'h0817);
    apply(32'd1000000);    check_all("v1e6", 16'h0000);
    apply(32'd2147483648); check_all("v2p31", 16'h3648);

    // Mid-stream reset: reset wins over a new input value.
    apply(32'd4321);
    check_all("pre_rst_4321", 16'h4321);
    @(negedge clk);
    reset = 1'b1;
    bus_if.bin_in = 32'd5678;
    @(posedge clk); #1;
    check_all("mid_rst", 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_all("post_rst_5678", 16'h5678);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_bcd_seg7_decoder
